// File: rtl/ab_pkg.sv
// Shared definitions for the A/B sequence detector and its stimulus generator.
package ab_pkg;

    // Stimulus generator run states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        HOLD = 3'd2,
        GAP  = 3'd3,
        FIN  = 3'd4
    } state_t;

    // Detector states: S2 is the Q=1 state (A seen, then B held)
    typedef enum logic [1:0] {
        DET_S0 = 2'd0,
        DET_S1 = 2'd1,
        DET_S2 = 2'd2
    } det_state_t;

    // Idle cycles the detector needs to walk S2 -> S1 -> S0 before the next ARM
    localparam int unsigned MIN_GAP = 2;

endpackage

// File: rtl/ab_q_checker.sv
// Compares detector Q against the expected waveform (HOLD delayed one cycle)
// and tallies bursts whose Q waveform was clean.
module ab_q_checker
    import ab_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q_in,
    input  logic             clear,
    input  logic             arm,
    input  logic             hold,
    input  logic             cmp_en,
    input  logic             last_gap,
    output logic [CNT_W-1:0] match_cnt,
    output logic             err
);

    logic             exp_q_q, exp_q_d;
    logic             burst_bad_q, burst_bad_d;
    logic [CNT_W-1:0] match_q, match_d;
    logic             err_q, err_d;
    logic             mismatch_c;

    always_comb begin
        exp_q_d     = hold;
        burst_bad_d = burst_bad_q;
        match_d     = match_q;
        err_d       = err_q;
        mismatch_c  = cmp_en && (q_in != exp_q_q);

        if (arm) begin
            burst_bad_d = 1'b0;
        end else if (mismatch_c) begin
            burst_bad_d = 1'b1;
        end

        if (mismatch_c) begin
            err_d = 1'b1;
        end

        // A burst counts only if it was clean through its final GAP cycle
        if (last_gap && !burst_bad_q && !mismatch_c && (match_q != '1)) begin
            match_d = match_q + CNT_W'(1);
        end

        if (clear) begin
            burst_bad_d = 1'b0;
            match_d     = '0;
            err_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q_q     <= 1'b0;
            burst_bad_q <= 1'b0;
            match_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            exp_q_q     <= exp_q_d;
            burst_bad_q <= burst_bad_d;
            match_q     <= match_d;
            err_q       <= err_d;
        end
    end

    assign match_cnt = match_q;
    assign err       = err_q;

endmodule

// File: rtl/ab_stim_gen.sv
// Burst generator driving A-then-B pulse trains into the A/B detector and
// checking its Q response through ab_q_checker.
module ab_stim_gen
    import ab_pkg::*;
#(
    parameter int unsigned HOLD_W = 4,
    parameter int unsigned GAP_W  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic [GAP_W-1:0]  gap_len,
    input  logic [CNT_W-1:0]  burst_cnt,
    output logic              A,
    output logic              B,
    input  logic              q_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              err
);

    localparam int unsigned TMR_W = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;

    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              a_q, a_d;
    logic              b_q, b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_acc_c;
    logic              last_gap_c;

    // Next-state, config latch and phase timer
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        remain_d    = remain_q;
        tmr_d       = tmr_q;
        start_acc_c = 1'b0;
        last_gap_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc_c = 1'b1;
                    hold_d      = (hold_len == '0) ? HOLD_W'(1) : hold_len;
                    gap_d       = (gap_len < GAP_W'(MIN_GAP)) ? GAP_W'(MIN_GAP) : gap_len;
                    remain_d    = burst_cnt;
                    state_d     = (burst_cnt == '0) ? FIN : ARM;
                end
            end
            ARM: begin
                state_d = HOLD;
                tmr_d   = TMR_W'(hold_q);
            end
            HOLD: begin
                if (tmr_q == TMR_W'(1)) begin
                    state_d = GAP;
                    tmr_d   = TMR_W'(gap_q);
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            GAP: begin
                if (tmr_q == TMR_W'(1)) begin
                    last_gap_c = 1'b1;
                    remain_d   = remain_q - CNT_W'(1);
                    state_d    = (remain_q == CNT_W'(1)) ? FIN : ARM;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs decoded from the next state so they line up with state_q
        a_d    = (state_d == ARM);
        b_d    = (state_d == HOLD);
        busy_d = (state_d == ARM) || (state_d == HOLD) || (state_d == GAP);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            gap_q    <= '0;
            remain_q <= '0;
            tmr_q    <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
            remain_q <= remain_d;
            tmr_q    <= tmr_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    ab_q_checker #(
        .CNT_W(CNT_W)
    ) u_q_checker (
        .clk      (clk),
        .reset    (reset),
        .q_in     (q_in),
        .clear    (start_acc_c),
        .arm      (state_q == ARM),
        .hold     (state_q == HOLD),
        .cmp_en   ((state_q == HOLD) || (state_q == GAP)),
        .last_gap (last_gap_c),
        .match_cnt(match_cnt),
        .err      (err)
    );

    assign A    = a_q;
    assign B    = b_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ab_stim_gen.sv
// Directed bench: ab_stim_gen driving a behavioural A/B detector, table-driven runs
// plus hand-written reset and busy-start sequences.
module tb_ab_stim_gen;
    import ab_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] hold_len;
    logic [3:0] gap_len;
    logic [7:0] burst_cnt;
    logic       A, B;
    logic       q_in;
    logic       busy, done;
    logic [7:0] match_cnt;
    logic       err;

    int nerr = 0;
    int nchk = 0;

    det_state_t det_st;
    logic       force_q0 = 1'b0;

    always #5 clk = ~clk;

    // Reference detector: Q after A then B, held while B stays high
    always @(posedge clk) begin
        if (reset) begin
            det_st <= DET_S0;
        end else begin
            case (det_st)
                DET_S0:  det_st <= A ? DET_S1 : DET_S0;
                DET_S1:  det_st <= B ? DET_S2 : (A ? DET_S1 : DET_S0);
                DET_S2:  det_st <= B ? DET_S2 : DET_S1;
                default: det_st <= DET_S0;
            endcase
        end
    end

    assign q_in = force_q0 ? 1'b0 : (det_st == DET_S2);

    ab_stim_gen #(
        .HOLD_W(4),
        .GAP_W (4),
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .hold_len (hold_len),
        .gap_len  (gap_len),
        .burst_cnt(burst_cnt),
        .A        (A),
        .B        (B),
        .q_in     (q_in),
        .busy     (busy),
        .done     (done),
        .match_cnt(match_cnt),
        .err      (err)
    );

    typedef struct {
        int hold;
        int gap;
        int bursts;
        int stuck;      // burst index (1-based) with Q forced low, 0 = none
        int poke;       // re-start and change config mid-run
        int exp_len;    // cycles from start-accept to done
        int exp_match;
        int exp_err;
        int exp_a;
        int exp_b;
        int exp_err_n;  // cycle on which err first reads 1, 0 = never
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int expv);
        nchk++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int n, a_cnt, b_cnt, bidx, first_err;
        a_cnt = 0; b_cnt = 0; bidx = 0; first_err = 0;
        @(negedge clk);
        hold_len  = 4'(v.hold);
        gap_len   = 4'(v.gap);
        burst_cnt = 8'(v.bursts);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 400) begin
            if (A) begin
                a_cnt++;
                bidx++;
            end
            if (B) b_cnt++;
            if (err && first_err == 0) first_err = n;
            force_q0 = (v.stuck != 0) && (bidx == v.stuck);
            start = (v.poke != 0) && (n == 3);
            if (start) begin
                hold_len  = 4'd9;
                burst_cnt = 8'd7;
            end
            @(negedge clk);
            n++;
        end
        force_q0 = 1'b0;
        chk({name, " run_len"}, n, v.exp_len);
        chk({name, " busy_at_done"}, int'(busy), 0);
        chk({name, " match_cnt"}, int'(match_cnt), v.exp_match);
        chk({name, " err"}, int'(err), v.exp_err);
        chk({name, " a_cycles"}, a_cnt, v.exp_a);
        chk({name, " b_cycles"}, b_cnt, v.exp_b);
        chk({name, " err_first_cycle"}, first_err, v.exp_err_n);
        // A start landing on the done cycle must be dropped
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, " start_in_fin_busy"}, int'(busy), 0);
        chk({name, " start_in_fin_done"}, int'(done), 0);
    endtask

    initial begin
        int n, b_rise;
        logic b_prev;

        //            hold gap  n  stk pk len match err a  b  errn
        vecs[0] = '{  3,  2,  1,  0, 0,  7,  1,  0,  1,  3,  0 };
        vecs[1] = '{  0,  0,  4,  0, 0, 17,  4,  0,  4,  4,  0 };
        vecs[2] = '{  2,  3,  3,  2, 0, 19,  2,  1,  3,  6, 10 };
        vecs[3] = '{  5,  5,  0,  0, 0,  1,  0,  0,  0,  0,  0 };
        vecs[4] = '{ 15,  1,  2,  0, 0, 37,  2,  0,  2, 30,  0 };
        vecs[5] = '{  2,  2,  2,  0, 1, 11,  2,  0,  2,  4,  0 };

        reset = 1'b1; start = 1'b0;
        hold_len = '0; gap_len = '0; burst_cnt = '0;
        repeat (3) @(negedge clk);
        chk("reset A", int'(A), 0);
        chk("reset B", int'(B), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset match_cnt", int'(match_cnt), 0);
        chk("reset err", int'(err), 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during HOLD of the second burst aborts the run
        @(negedge clk);
        hold_len = 4'd4; gap_len = 4'd2; burst_cnt = 8'd2; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n      = 0;
        b_rise = 0;
        b_prev = 1'b0;
        while (b_rise < 2 && n < 100) begin
            if (B && !b_prev) b_rise++;
            b_prev = B;
            if (b_rise < 2) begin
                @(negedge clk);
                n++;
            end
        end
        chk("midrun second_hold_seen", b_rise, 2);
        chk("midrun match_before_reset", int'(match_cnt), 1);
        chk("midrun busy_before_reset", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrun_reset A", int'(A), 0);
        chk("midrun_reset B", int'(B), 0);
        chk("midrun_reset busy", int'(busy), 0);
        chk("midrun_reset done", int'(done), 0);
        chk("midrun_reset match_cnt", int'(match_cnt), 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset no_done", int'(done), 0);
        end

        run_vec(vecs[0], "after_reset");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/ab_stim_gen.md
Name: ab_stim_gen

Overview:
- Transmit-side counterpart to the team's A/B sequence detector (Q asserts after A then B, holds while B stays high).
- Generates bursts of A-then-B pulse trains that drive the detector to its Q=1 state for a programmed duration.
- Checks the detector's Q output cycle-by-cycle against the expected waveform and counts clean bursts.
- Used as an on-chip stimulus/self-test source alongside the detector, sharing its clock and reset.

Parameters:
HOLD_W, 4, width of hold_len (cycles B is held high per burst)
GAP_W, 4, width of gap_len (idle cycles between bursts)
CNT_W, 8, width of burst_cnt and match_cnt

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a run; ignored while busy=1
hold_len  input  HOLD_W  B-high cycles per burst; 0 treated as 1; latched on accepted start
gap_len  input  GAP_W  idle cycles after each burst; values <2 treated as 2; latched on accepted start
burst_cnt  input  CNT_W  number of bursts in the run; latched on accepted start
A  output  1  stimulus A to detector (registered)
B  output  1  stimulus B to detector (registered)
q_in  input  1  detector Q, sampled every cycle
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the run completes
match_cnt  output  CNT_W  number of bursts whose Q waveform matched
err  output  1  sticky; set on any Q mismatch; cleared on accepted start

Behaviour:
- Reset (synchronous): state=IDLE; A=0, B=0, busy=0, done=0, match_cnt=0, err=0; config registers and counters cleared. Reset mid-run aborts immediately. No done pulse. The detector is expected to share the same reset.
- FSM states: IDLE, ARM, HOLD, GAP, FIN.
- IDLE: A=0, B=0. On start:
  - latch config;
  - clear match_cnt and err;
  - if burst_cnt==0, go to FIN; otherwise go to ARM. busy=1 from the next cycle.
- ARM: exactly 1 cycle with A=1, B=0, then HOLD.
- HOLD: A=0, B=1 for H = max(hold_len,1) cycles, then GAP.
- GAP: A=0, B=0 for G = max(gap_len,2) cycles.
  - The minimum of 2 lets the detector return through S1 to S0 before the next ARM.
  - At the last GAP cycle, evaluate the burst. If bursts remain (remaining counter decremented at end of GAP), go to ARM; otherwise go to FIN.
- FIN: done=1 for 1 cycle, busy=0, return to IDLE. A start arriving in FIN is ignored.
- Expected Q:
  - exp_q = registered copy of (state==HOLD), i.e. HOLD delayed one cycle.
  - With ARM at cycle k, q_in must be 1 in cycles k+2..k+H+1 and 0 otherwise while busy.
  - Comparison is enabled only in HOLD and GAP states, not during the first ARM of a run.
- Per-burst flag: burst_bad is cleared on entering ARM and set on any q_in != exp_q.
  - At the last GAP cycle: if burst_bad=0 and no mismatch in that cycle, match_cnt increments (saturates at all-ones).
  - Any mismatch sets err in the following cycle; err stays set until the next accepted start.
- Timing and widths:
  - Burst period = 1 + H + G cycles.
  - Run length = burst_cnt*(1+H+G) + 1 (FIN) cycles after the start-accept cycle.
  - All counters are unsigned. Hold and gap counters count down from the latched value to 1.
- Config inputs may change freely while busy; only latched values are used.

Decomposition:
- Shared package ab_pkg holds state_t (IDLE, ARM, HOLD, GAP, FIN as logic [2:0]) and the constant MIN_GAP=2.
- The detector's state encoding also moves into ab_pkg so both ends share it.
- One natural sub-module: ab_q_checker (exp_q delay, compare, burst_bad, match_cnt, err), driven by state strobes from the main FSM.

Test Plan:
- Start with hold_len=3, gap_len=2, burst_cnt=1, connected to the real detector -> A=1 for 1 cycle, B=1 for 3 cycles, Q high 3 cycles; done pulse 7 cycles after start; match_cnt=1, err=0.
- burst_cnt=4, hold_len=0, gap_len=0 -> H=1, G=2 enforced; 4 periods of 4 cycles; match_cnt=4, err=0.
- Force q_in stuck at 0 during burst 2 of 3 -> err=1 from the cycle after the first mismatch; final match_cnt=2.
- burst_cnt=0 -> no A/B activity; done pulses 1 cycle after start; match_cnt=0.
- Assert start while busy, and change hold_len mid-run -> run continues unaltered with the original latched values; no restart.
- Assert reset during HOLD -> next cycle A=0, B=0, busy=0, match_cnt=0, no done pulse; a new start afterwards runs normally.
